// File: rtl/game_pkg.sv
// game_pkg: tile width, FSM state encoding and the packed-sequence tile extractor
// shared by the presenter and the player-input checker.
package game_pkg;
    localparam int TILE_W = 2;
    localparam int SEQ_W_MAX = 128;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;
    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ON   = ST_ON,
        S_OFF  = ST_OFF,
        S_FIN  = ST_FIN
    } state_t;
    // Tile i is {seq[2i], seq[2i+1]}: the even bit is the MSB.
    function automatic logic [TILE_W-1:0] tile_at(input logic [SEQ_W_MAX-1:0] seq, input logic [5:0] i);
        logic [6:0] b;
        b = {i, 1'b0};
        return {seq[b], seq[b | 7'd1]};
    endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter; expired flags the last cycle of a loaded phase.
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] count;
    assign expired = count == W'(1);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (en && count != '0)
            count <= count - W'(1);
endmodule

// File: rtl/sequence_presenter.sv
// sequence_presenter: plays the latched tile sequence back, each tile lit for
// ON_CYCLES then dark for OFF_CYCLES, and pulses done at the end.
module sequence_presenter
    import game_pkg::*;
#(
    parameter int MAX_LEN    = 9,
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*MAX_LEN-1:0] seq,
    input  logic [5:0]           seq_len,
    output logic                 tile_on,
    output logic [TILE_W-1:0]    tile_shown,
    output logic [5:0]           seq_counter,
    output logic                 busy,
    output logic                 done
);
    localparam int TW = $clog2((ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES) + 1);
    localparam logic [5:0] MAX6 = 6'(MAX_LEN);
    state_t               state;
    logic [2*MAX_LEN-1:0] seq_q;
    logic [5:0]           len_q;
    logic [5:0]           len_in;
    logic                 expired;
    logic                 load;
    logic                 last;
    logic                 timing;
    assign len_in = seq_len > MAX6 ? MAX6 : seq_len;
    assign timing = state == S_ON || state == S_OFF;
    assign last   = seq_counter == len_q - 6'd1;
    assign load   = (state == S_IDLE && start) || (timing && expired);
    phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (state == S_ON ? TW'(OFF_CYCLES) : TW'(ON_CYCLES)),
        .en         (timing),
        .expired    (expired)
    );
    // Outputs are set on the transition edge so they always match the state being entered.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= S_IDLE;
            seq_q       <= '0;
            len_q       <= '0;
            tile_on     <= 1'b0;
            tile_shown  <= '0;
            seq_counter <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else
            case (state)
                S_IDLE:
                    if (start) begin
                        seq_q       <= seq;
                        len_q       <= len_in;
                        seq_counter <= '0;
                        busy        <= 1'b1;
                        if (len_in == '0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state      <= S_ON;
                            tile_on    <= 1'b1;
                            tile_shown <= tile_at(SEQ_W_MAX'(seq), 6'd0);
                        end
                    end
                S_ON:
                    if (expired) begin
                        state   <= S_OFF;
                        tile_on <= 1'b0;
                    end
                S_OFF:
                    if (expired) begin
                        if (last) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state       <= S_ON;
                            seq_counter <= seq_counter + 6'd1;
                            tile_on     <= 1'b1;
                            tile_shown  <= tile_at(SEQ_W_MAX'(seq_q), seq_counter + 6'd1);
                        end
                    end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
endmodule

// File: tb/tb_sequence_presenter.sv
// tb_sequence_presenter: scoreboard bench; each playback pushes its expected tile
// windows and done cycle, and a negedge monitor pops and compares them.
module tb_sequence_presenter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [17:0] seq = '0;
    logic [5:0]  seq_len = '0;
    logic        tile_on;
    logic [1:0]  tile_shown;
    logic [5:0]  seq_counter;
    logic        busy;
    logic        done;

    typedef struct {
        int         cyc;
        logic [1:0] tile;
        logic [5:0] idx;
    } tile_exp_t;

    tile_exp_t   tile_q[$];
    int          done_q[$];
    tile_exp_t   e;
    int          d;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rise_cyc = 0;
    int          c;
    logic        prev_on = 1'b0;
    logic [17:0] s3;

    sequence_presenter dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .seq         (seq),
        .seq_len     (seq_len),
        .tile_on     (tile_on),
        .tile_shown  (tile_shown),
        .seq_counter (seq_counter),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_tile(input logic [17:0] sv, input int i);
        logic [17:0] t;
        t = sv >> (2 * i);
        return {t[0], t[1]};
    endfunction

    // Start sampled at the edge ending cycle c: tile i lights at c+1+6i, done at c+1+6n.
    task automatic push_play(input int cs, input logic [17:0] sv, input logic [5:0] l);
        int n;
        n = l > 6'd9 ? 9 : int'(l);
        for (int i = 0; i < n; i++)
            tile_q.push_back('{cs + 1 + i * 6, model_tile(sv, i), 6'(i)});
        done_q.push_back(cs + 1 + n * 6);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic play(input logic [17:0] sv, input logic [5:0] l);
        seq = sv;
        seq_len = l;
        start = 1'b1;
        push_play(cyc, sv, l);
        tick(1);
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        chk(tag, tile_q.size() + done_q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tile_on"}, tile_on, 0);
        chk({tag, "_tile_shown"}, tile_shown, 0);
        chk({tag, "_seq_counter"}, seq_counter, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    always @(negedge clk) begin
        if (tile_on && !prev_on) begin
            rise_cyc = cyc;
            if (tile_q.size() == 0)
                chk("tile_unexpected", 1, 0);
            else begin
                e = tile_q.pop_front();
                chk("tile_cycle", cyc, e.cyc);
                chk("tile_shown", tile_shown, e.tile);
                chk("tile_index", seq_counter, e.idx);
                chk("tile_busy", busy, 1);
            end
        end
        if (!tile_on && prev_on && !reset)
            chk("on_length", cyc - rise_cyc, 4);
        if (done) begin
            if (done_q.size() == 0)
                chk("done_unexpected", 1, 0);
            else begin
                d = done_q.pop_front();
                chk("done_cycle", cyc, d);
                chk("done_busy", busy, 1);
                chk("done_tile_off", tile_on, 0);
            end
        end
        prev_on = tile_on;
    end

    initial begin
        tick(2);
        chk_zero("reset");
        reset = 1'b0;
        tick(2);

        play(18'h00031, 6'd3);
        tick(25);
        drain("t1_drain");
        chk("t1_idle_busy", busy, 0);
        chk("t1_last_index", seq_counter, 2);

        play(18'h3ffff, 6'd0);
        chk("t2_busy_fin", busy, 1);
        chk("t2_no_tile", tile_on, 0);
        tick(1);
        chk("t2_busy_after", busy, 0);
        tick(3);
        drain("t2_drain");

        s3 = 18'($urandom);
        play(s3, 6'd12);
        tick(60);
        drain("t3_drain");
        chk("t3_last_index", seq_counter, 8);

        play(18'h00031, 6'd3);
        tick(7);
        reset = 1'b1;
        #1;
        chk_zero("t4_reset");
        tile_q.delete();
        done_q.delete();
        tick(2);
        reset = 1'b0;
        tick(1);
        play(18'h00031, 6'd3);
        tick(25);
        drain("t4_drain");

        play(18'h00031, 6'd3);
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        seq = 18'h3ffff;
        seq_len = 6'd1;
        tick(20);
        drain("t5_drain");

        seq = 18'h00002;
        seq_len = 6'd1;
        start = 1'b1;
        c = cyc;
        push_play(c, seq, seq_len);
        push_play(c + 8, seq, seq_len);
        tick(12);
        start = 1'b0;
        tick(10);
        drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
